hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
Pipeline control unit for the 5-stage core. It sequences the IF/ID and ID/EX pipeline registers and the PC write enable. It detects load-use hazards, multi-cycle multiply/divide occupancy, taken branches resolved in EX, and jumps decoded in ID. From these it drives stall (hold) and flush (bubble) controls, and keeps a saturating stall-cycle performance counter.

Parameters:
MD_CYCLES, 4, total stall cycles for a mult/div instruction held in ID (legal range 2..255)
CNT_W, 16, width of the stall performance counter
RA_W, 5, register address width

Ports:
Clk  in  1  pipeline clock; all state updates on posedge
Rst  in  1  synchronous active-low reset, sampled on posedge Clk
IDEX_MemRead  in  1  instruction in EX is a load
IDEX_Rt  in  RA_W  load destination register in EX
IFID_Rs  in  RA_W  source register of the instruction in ID
IFID_Rt  in  RA_W  second source register of the instruction in ID
IFID_UsesRt  in  1  instruction in ID reads Rt as a source
ID_MulDiv  in  1  instruction in ID is mult/div
ID_Jump  in  1  instruction in ID is j/jal/jr
EX_BranchTaken  in  1  branch in EX resolved taken
PCWrite  out  1  PC update enable
IFID_Write  out  1  IF/ID register load enable (0 = hold)
IFID_flush  out  1  zero the instruction captured into IF/ID
IDEX_flush  out  1  insert a bubble into ID/EX
Stall_count  out  CNT_W  cycles with PCWrite=0 since reset, saturating

Behaviour:
- State register: RUN, MD_WAIT. Down-counter md_cnt is 8 bits wide.
- Reset: while Rst==0 at posedge, the next state is RUN, md_cnt=0 and Stall_count=0. In any cycle where Rst is low, the outputs are forced to PCWrite=0, IFID_Write=0, IFID_flush=1, IDEX_flush=1. Reset mid-MD_WAIT aborts the wait with no release cycle.
- The hazard terms are computed combinationally in the current cycle, with no added latency:
  - lu = IDEX_MemRead & (IDEX_Rt!=0) & ((IDEX_Rt==IFID_Rs) | (IFID_UsesRt & IDEX_Rt==IFID_Rt))
- RUN, outputs by priority (first match wins):
  1. EX_BranchTaken: PCWrite=1, IFID_Write=1, IFID_flush=1, IDEX_flush=1. Stay in RUN. Load-use, mult/div and jump in ID are ignored because that instruction is wrong-path.
  2. lu: PCWrite=0, IFID_Write=0, IFID_flush=0, IDEX_flush=1. Stay in RUN. This is exactly a 1-cycle stall; the next cycle re-evaluates.
  3. ID_MulDiv: same outputs as the stall case. Next state MD_WAIT, md_cnt<=MD_CYCLES-1.
  4. ID_Jump: PCWrite=1, IFID_Write=1, IFID_flush=1, IDEX_flush=0.
  5. Otherwise: PCWrite=1, IFID_Write=1, both flushes 0.
- MD_WAIT:
  - md_cnt>0: stall outputs (PCWrite=0, IFID_Write=0, IDEX_flush=1, IFID_flush=0) and md_cnt decrements.
  - md_cnt==0 (release cycle): PCWrite=1, IFID_Write=1, both flushes 0. Next state is RUN. ID_MulDiv, lu and ID_Jump are not evaluated in this cycle, so the held mult/div advances into EX without retriggering.
  - EX_BranchTaken cannot occur because EX holds bubbles. Bench asserts it is 0 in MD_WAIT; RTL ignores it there.
- A mult/div therefore stalls for exactly MD_CYCLES cycles, followed by one release cycle.
- Stall_count increments by 1 on each posedge where Rst==1 and PCWrite==0. It holds at 2^CNT_W-1 once reached.
- Outputs are Mealy in RUN and Moore in MD_WAIT. No output is registered; the pipeline registers sample them on their own edges.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state enum {RUN, MD_WAIT}
  - constant REG_ZERO=0
  - RA_W default
  - a control-bundle struct {PCWrite, IFID_Write, IFID_flush, IDEX_flush} with named constants CTRL_NORMAL, CTRL_STALL, CTRL_BRFLUSH, CTRL_JFLUSH, CTRL_RESET
- One natural sub-module: load_use_detect, a purely combinational producer of lu. It is reused later by the forwarding unit.

Test Plan:
1. Rst=0 for 3 cycles, then 1 -> outputs are 0/0/1/1 during reset; after release, RUN, CTRL_NORMAL and Stall_count=0.
2. IDEX_MemRead=1, IDEX_Rt=8, IFID_Rs=8 for one cycle, then the load moves on -> exactly one cycle of PCWrite=0, IFID_Write=0, IDEX_flush=1; Stall_count=1.
3. Same as 2 but IDEX_Rt=0 (or IFID_Rt=8 with IFID_UsesRt=0) -> no stall.
4. EX_BranchTaken=1 together with the load-use condition and ID_MulDiv=1 -> CTRL_BRFLUSH (1,1,1,1), stays in RUN, no MD_WAIT entered, Stall_count unchanged.
5. MD_CYCLES=4, ID_MulDiv held high -> 4 stall cycles (PCWrite=0), then one release cycle with CTRL_NORMAL despite ID_MulDiv=1, then RUN; Stall_count=4.
6. Rst=0 during the 2nd MD_WAIT cycle -> reset outputs that cycle; after release, RUN with CTRL_NORMAL and no release cycle. Separately, force Stall_count near 2^16-1 -> it saturates at 65535.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control slice:
// controller state, register-zero constant and the control bundle.
package pipe_ctrl_pkg;

    localparam int RA_W_DEFAULT = 5;
    localparam int REG_ZERO     = 0;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } ctrl_state_t;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_flush;
    } ctrl_t;

    localparam ctrl_t CTRL_NORMAL  = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b0};
    localparam ctrl_t CTRL_STALL   = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, idex_flush: 1'b1};
    localparam ctrl_t CTRL_BRFLUSH = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1, idex_flush: 1'b1};
    localparam ctrl_t CTRL_JFLUSH  = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1, idex_flush: 1'b0};
    localparam ctrl_t CTRL_RESET   = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1, idex_flush: 1'b1};

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use detector: a load in EX writes a register that the
// instruction in ID reads. Register zero never creates a dependency.
module load_use_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int RA_W = RA_W_DEFAULT
) (
    input  logic            i_idex_memread,
    input  logic [RA_W-1:0] i_idex_rt,
    input  logic [RA_W-1:0] i_ifid_rs,
    input  logic [RA_W-1:0] i_ifid_rt,
    input  logic            i_ifid_uses_rt,
    output logic            o_lu
);

    logic w_rs_match;
    logic w_rt_match;
    logic w_dst_nonzero;

    assign w_dst_nonzero = (i_idex_rt != RA_W'(REG_ZERO));
    assign w_rs_match    = (i_idex_rt == i_ifid_rs);
    assign w_rt_match    = i_ifid_uses_rt & (i_idex_rt == i_ifid_rt);
    assign o_lu          = i_idex_memread & w_dst_nonzero & (w_rs_match | w_rt_match);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: branch/jump flushes, load-use and mult/div stalls,
// plus a saturating count of cycles in which the PC was held.
module hazard_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_CYCLES = 4,
    parameter int CNT_W     = 16,
    parameter int RA_W      = RA_W_DEFAULT
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             IDEX_MemRead,
    input  logic [RA_W-1:0]  IDEX_Rt,
    input  logic [RA_W-1:0]  IFID_Rs,
    input  logic [RA_W-1:0]  IFID_Rt,
    input  logic             IFID_UsesRt,
    input  logic             ID_MulDiv,
    input  logic             ID_Jump,
    input  logic             EX_BranchTaken,
    output logic             PCWrite,
    output logic             IFID_Write,
    output logic             IFID_flush,
    output logic             IDEX_flush,
    output logic [CNT_W-1:0] Stall_count
);

    ctrl_state_t      r_state;
    ctrl_state_t      w_state_next;
    logic [7:0]       r_md_cnt;
    logic [7:0]       w_md_cnt_next;
    logic [CNT_W-1:0] r_stall_count;
    ctrl_t            w_ctrl;
    logic             w_lu;

    load_use_detect #(
        .RA_W (RA_W)
    ) u_load_use_detect (
        .i_idex_memread (IDEX_MemRead),
        .i_idex_rt      (IDEX_Rt),
        .i_ifid_rs      (IFID_Rs),
        .i_ifid_rt      (IFID_Rt),
        .i_ifid_uses_rt (IFID_UsesRt),
        .o_lu           (w_lu)
    );

    always_comb begin
        w_ctrl        = CTRL_NORMAL;
        w_state_next  = r_state;
        w_md_cnt_next = r_md_cnt;
        if (!Rst) begin
            w_ctrl = CTRL_RESET;
        end else begin
            unique case (r_state)
                RUN: begin
                    // The instruction in ID is wrong-path when a branch resolves taken.
                    if (EX_BranchTaken) begin
                        w_ctrl = CTRL_BRFLUSH;
                    end else if (w_lu) begin
                        w_ctrl = CTRL_STALL;
                    end else if (ID_MulDiv) begin
                        w_ctrl        = CTRL_STALL;
                        w_state_next  = MD_WAIT;
                        w_md_cnt_next = 8'(MD_CYCLES - 1);
                    end else if (ID_Jump) begin
                        w_ctrl = CTRL_JFLUSH;
                    end
                end
                MD_WAIT: begin
                    // Release cycle ignores ID so the held mult/div cannot retrigger.
                    if (r_md_cnt != 8'd0) begin
                        w_ctrl        = CTRL_STALL;
                        w_md_cnt_next = r_md_cnt - 8'd1;
                    end else begin
                        w_ctrl       = CTRL_NORMAL;
                        w_state_next = RUN;
                    end
                end
                default: begin
                    w_state_next = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_state       <= RUN;
            r_md_cnt      <= 8'd0;
            r_stall_count <= '0;
        end else begin
            r_state  <= w_state_next;
            r_md_cnt <= w_md_cnt_next;
            if (!w_ctrl.pc_write && (r_stall_count != {CNT_W{1'b1}})) begin
                r_stall_count <= r_stall_count + 1'b1;
            end
        end
    end

    assign PCWrite     = w_ctrl.pc_write;
    assign IFID_Write  = w_ctrl.ifid_write;
    assign IFID_flush  = w_ctrl.ifid_flush;
    assign IDEX_flush  = w_ctrl.idex_flush;
    assign Stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed steps then random
// stimulus against a queue-based reference model of the control rules.
module tb_hazard_stall_ctrl;

    localparam int MD_CYCLES = 4;
    localparam int RA_W      = 5;

    logic            Clk = 1'b0;
    logic            Rst;
    logic            IDEX_MemRead;
    logic [RA_W-1:0] IDEX_Rt;
    logic [RA_W-1:0] IFID_Rs;
    logic [RA_W-1:0] IFID_Rt;
    logic            IFID_UsesRt;
    logic            ID_MulDiv;
    logic            ID_Jump;
    logic            EX_BranchTaken;

    logic        PCWrite, IFID_Write, IFID_flush, IDEX_flush;
    logic [15:0] Stall_count;
    logic        s_PCWrite, s_IFID_Write, s_IFID_flush, s_IDEX_flush;
    logic [3:0]  s_Stall_count;

    always #5 Clk = ~Clk;

    hazard_stall_ctrl #(.MD_CYCLES(MD_CYCLES), .CNT_W(16), .RA_W(RA_W)) u_dut (
        .Clk(Clk), .Rst(Rst), .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt),
        .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_UsesRt(IFID_UsesRt),
        .ID_MulDiv(ID_MulDiv), .ID_Jump(ID_Jump), .EX_BranchTaken(EX_BranchTaken),
        .PCWrite(PCWrite), .IFID_Write(IFID_Write), .IFID_flush(IFID_flush),
        .IDEX_flush(IDEX_flush), .Stall_count(Stall_count)
    );

    // Narrow-counter instance so saturation is reachable in a short run.
    hazard_stall_ctrl #(.MD_CYCLES(MD_CYCLES), .CNT_W(4), .RA_W(RA_W)) u_dut_sat (
        .Clk(Clk), .Rst(Rst), .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt),
        .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_UsesRt(IFID_UsesRt),
        .ID_MulDiv(ID_MulDiv), .ID_Jump(ID_Jump), .EX_BranchTaken(EX_BranchTaken),
        .PCWrite(s_PCWrite), .IFID_Write(s_IFID_Write), .IFID_flush(s_IFID_flush),
        .IDEX_flush(s_IDEX_flush), .Stall_count(s_Stall_count)
    );

    // Reference model: pending forced controls {PCWrite,IFID_Write,IFID_flush,IDEX_flush}.
    bit [3:0] forced_q[$];
    int       cnt16;
    int       cnt4;
    int       passed = 0;
    int       total  = 0;
    int       cyc    = 0;

    localparam bit [3:0] EXP_NORMAL  = 4'b1100;
    localparam bit [3:0] EXP_STALL   = 4'b0001;
    localparam bit [3:0] EXP_BRFLUSH = 4'b1111;
    localparam bit [3:0] EXP_JFLUSH  = 4'b1110;
    localparam bit [3:0] EXP_RESET   = 4'b0011;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp_v);
    endtask

    function automatic bit model_lu();
        return IDEX_MemRead && (IDEX_Rt != 0) &&
               ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));
    endfunction

    function automatic bit [3:0] model_ctrl();
        if (!Rst)                  return EXP_RESET;
        if (forced_q.size() != 0)  return forced_q[0];
        if (EX_BranchTaken)        return EXP_BRFLUSH;
        if (model_lu())            return EXP_STALL;
        if (ID_MulDiv)             return EXP_STALL;
        if (ID_Jump)               return EXP_JFLUSH;
        return EXP_NORMAL;
    endfunction

    task automatic run_cycle(input string tag);
        bit [3:0] exp_c;
        bit       in_wait;
        @(negedge Clk);
        exp_c   = model_ctrl();
        in_wait = Rst && (forced_q.size() != 0);
        if (in_wait) check({tag, "_br_in_wait"}, 32'(EX_BranchTaken), 32'd0);
        check({tag, "_ctrl"}, {28'd0, PCWrite, IFID_Write, IFID_flush, IDEX_flush}, 32'(exp_c));
        check({tag, "_ctrl_sat"}, {28'd0, s_PCWrite, s_IFID_Write, s_IFID_flush, s_IDEX_flush}, 32'(exp_c));
        check({tag, "_cnt16"}, 32'(Stall_count), 32'(cnt16));
        check({tag, "_cnt4"}, 32'(s_Stall_count), 32'(cnt4));
        $display("cyc %0d %s rst=%0b ctrl=%b exp=%b cnt=%0d sat=%0d",
                 cyc, tag, Rst, {PCWrite, IFID_Write, IFID_flush, IDEX_flush}, exp_c,
                 Stall_count, s_Stall_count);
        @(posedge Clk);
        if (!Rst) begin
            forced_q.delete();
            cnt16 = 0;
            cnt4  = 0;
        end else begin
            if (forced_q.size() != 0) begin
                void'(forced_q.pop_front());
            end else if (!EX_BranchTaken && !model_lu() && ID_MulDiv) begin
                // Trigger cycle is stall 1; the rest follow, then one release cycle.
                for (int k = 1; k < MD_CYCLES; k++) forced_q.push_back(EXP_STALL);
                forced_q.push_back(EXP_NORMAL);
            end
            if (exp_c[3] == 1'b0) begin
                if (cnt16 < 65535) cnt16++;
                if (cnt4 < 15)     cnt4++;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic idle_inputs();
        Rst            = 1'b1;
        IDEX_MemRead   = 1'b0;
        IDEX_Rt        = '0;
        IFID_Rs        = '0;
        IFID_Rt        = '0;
        IFID_UsesRt    = 1'b0;
        ID_MulDiv      = 1'b0;
        ID_Jump        = 1'b0;
        EX_BranchTaken = 1'b0;
    endtask

    initial begin
        cnt16 = 0;
        cnt4  = 0;
        idle_inputs();

        // Reset for three cycles, then release.
        Rst = 1'b0;
        for (int i = 0; i < 3; i++) run_cycle("reset");
        Rst = 1'b1;
        run_cycle("post_reset");

        // Load-use on Rs: one stall cycle.
        IDEX_MemRead = 1'b1; IDEX_Rt = 5'd8; IFID_Rs = 5'd8;
        run_cycle("lu_rs");
        idle_inputs();
        run_cycle("lu_done");

        // No stall: destination is r0, or Rt matches but is not read.
        IDEX_MemRead = 1'b1; IDEX_Rt = 5'd0; IFID_Rs = 5'd0;
        run_cycle("lu_r0");
        IDEX_Rt = 5'd8; IFID_Rs = 5'd3; IFID_Rt = 5'd8; IFID_UsesRt = 1'b0;
        run_cycle("lu_rt_unused");
        IFID_UsesRt = 1'b1;
        run_cycle("lu_rt_used");
        idle_inputs();

        // Taken branch overrides load-use and mult/div.
        IDEX_MemRead = 1'b1; IDEX_Rt = 5'd8; IFID_Rs = 5'd8; ID_MulDiv = 1'b1; EX_BranchTaken = 1'b1;
        run_cycle("br_prio");
        idle_inputs();
        run_cycle("br_after");

        // Jump in ID.
        ID_Jump = 1'b1;
        run_cycle("jump");
        idle_inputs();

        // Mult/div held high: MD_CYCLES stalls then a release cycle.
        ID_MulDiv = 1'b1;
        for (int i = 0; i < MD_CYCLES + 2; i++) run_cycle("muldiv");
        idle_inputs();
        run_cycle("muldiv_done");

        // Reset during the second wait cycle aborts without a release cycle.
        ID_MulDiv = 1'b1;
        run_cycle("md_abort_trig");
        ID_MulDiv = 1'b0;
        run_cycle("md_abort_wait1");
        Rst = 1'b0;
        run_cycle("md_abort_rst");
        Rst = 1'b1;
        run_cycle("md_abort_after");
        run_cycle("md_abort_after");

        // Continuous load-use saturates the narrow counter.
        IDEX_MemRead = 1'b1; IDEX_Rt = 5'd9; IFID_Rs = 5'd9;
        for (int i = 0; i < 20; i++) run_cycle("saturate");
        idle_inputs();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            Rst            = ($urandom_range(0, 49) != 0);
            IDEX_MemRead   = 1'($urandom_range(0, 1));
            IDEX_Rt        = 5'($urandom_range(0, 3));
            IFID_Rs        = 5'($urandom_range(0, 3));
            IFID_Rt        = 5'($urandom_range(0, 3));
            IFID_UsesRt    = 1'($urandom_range(0, 1));
            ID_MulDiv      = ($urandom_range(0, 5) == 0);
            ID_Jump        = ($urandom_range(0, 4) == 0);
            EX_BranchTaken = (forced_q.size() == 0) && ($urandom_range(0, 5) == 0);
            run_cycle("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
